// File: rtl/mem_arbiter.sv
// Arbitrates three requesters onto one SDRAM byte port: fixed priority dl > dma > cpu, IDLE->ISSUE->WAIT->DONE, 4 cycles overhead.
// Requests are held off (no queue) during a transaction; optional CPU starvation guard under MEM_ARB_CPU_GUARD_EN.
module mem_arbiter #(
  parameter int AW       = 25,
  parameter int TIMEOUT  = 64,
  parameter int MAX_WAIT = 16
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_ack,
  input  logic          dma_req,
  input  logic [15:0]   dma_addr,
  output logic          dma_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_data,
  output logic          cpu_ack,
  output logic [7:0]    rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic [1:0]    owner,
  output logic          busy,
  output logic          timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DL   = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  localparam int             TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          req_q, req_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          terr_q, terr_d;
  logic          cpu_boost;

`ifdef MEM_ARB_CPU_GUARD_EN
  logic [4:0] cpu_wait_q, cpu_wait_d;
  logic       cpu_grant;

  assign cpu_boost = (cpu_wait_q >= 5'(MAX_WAIT));
  assign cpu_grant = (state_q == S_IDLE) && (owner_d == OWN_CPU);

  always_comb begin
    cpu_wait_d = cpu_wait_q;
    if (cpu_grant) begin
      cpu_wait_d = 5'd0;
    end else if (cpu_req && owner_q != OWN_CPU && cpu_wait_q != 5'h1f) begin
      cpu_wait_d = cpu_wait_q + 5'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cpu_wait_q <= 5'd0;
    else          cpu_wait_q <= cpu_wait_d;
  end
`else
  assign cpu_boost = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    to_cnt_d = to_cnt_q;
    terr_d   = terr_q;
    case (state_q)
      S_IDLE: begin
        if (dl_req) begin
          owner_d = OWN_DL;
          addr_d  = dl_addr;
          we_d    = 1'b1;
          din_d   = dl_data;
          state_d = S_ISSUE;
        end else if (cpu_req && (cpu_boost || !dma_req)) begin
          owner_d = OWN_CPU;
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          din_d   = cpu_data;
          state_d = S_ISSUE;
        end else if (dma_req) begin
          owner_d = OWN_DMA;
          addr_d  = AW'(dma_addr);
          we_d    = 1'b0;
          din_d   = 8'h00;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_d    = 1'b1;
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // a late ack in the final counter cycle still completes normally
        if (mem_ack) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = mem_dout;
          state_d = S_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          if (!we_q) rdata_d = 8'hFF;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      din_q    <= 8'h00;
      rdata_q  <= 8'h00;
      req_q    <= 1'b0;
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign dl_ack      = (state_q == S_DONE) && (owner_q == OWN_DL);
  assign dma_ack     = (state_q == S_DONE) && (owner_q == OWN_DMA);
  assign cpu_ack     = (state_q == S_DONE) && (owner_q == OWN_CPU);
  assign rdata       = rdata_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_din     = din_q;
  assign owner       = owner_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule
